rvga_membus_arbiter: RTL and testbench

- Shares one memory bus (membus) among num_channels cache-side requesters (cachebus), for example ifetch, memory stage and future DMA or debug ports.
- Generalises the fixed one-to-one cachebus-to-membus wiring of the core top level: N channels, selectable arbitration policy, registered request capture.
- Sits between the stage/L1 cachebus outputs and a single external membus master port.

---
 rtl/rvga_membus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_rvga_membus_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvga_membus_arbiter.sv
// Shares one membus master port among num_channels cachebus requesters.
// Round-robin or fixed-priority pick in IDLE, registered capture, one transaction in flight.
module rvga_membus_arbiter #(
    parameter int unsigned num_channels = 2,
    parameter int unsigned addr_width   = 32,
    parameter int unsigned data_width   = 32,
    parameter int unsigned arb_mode     = 0
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [num_channels*addr_width-1:0] ch_addr_i,
    input  logic [num_channels-1:0]            ch_read_i,
    input  logic [num_channels-1:0]            ch_write_i,
    input  logic [num_channels*data_width-1:0] ch_wdata_i,
    output logic [num_channels*data_width-1:0] ch_rdata_o,
    output logic [num_channels-1:0]            ch_resp_o,
    output logic [addr_width-1:0]              mem_addr_o,
    output logic                               mem_read_o,
    output logic                               mem_write_o,
    output logic [data_width-1:0]              mem_wdata_o,
    input  logic [data_width-1:0]              mem_rdata_i,
    input  logic                               mem_resp_i,
    output logic [num_channels-1:0]            grant_o,
    output logic                               busy_o
);

    localparam int unsigned ptr_w = (num_channels > 1) ? $clog2(num_channels) : 1;

    typedef logic [ptr_w-1:0]        ptr_t;
    typedef logic [num_channels-1:0] chan_t;
    typedef enum logic {IDLE, BUSY} state_e;

    state_e                  state_q;
    ptr_t                    rr_ptr_q;
    ptr_t                    gnt_idx_q;
    chan_t                   grant_q;
    logic                    busy_q;
    logic                    mem_read_q;
    logic                    mem_write_q;
    logic [addr_width-1:0]   mem_addr_q;
    logic [data_width-1:0]   mem_wdata_q;

    chan_t                   req;
    ptr_t                    base;
    logic                    hi_found;
    logic                    lo_found;
    ptr_t                    hi_idx;
    ptr_t                    lo_idx;

    logic                    found_d;
    ptr_t                    idx_d;
    chan_t                   grant_d;
    logic [addr_width-1:0]   addr_d;
    logic [data_width-1:0]   wdata_d;
    logic                    read_d;
    logic                    write_d;
    ptr_t                    rr_ptr_d;

    assign req = ch_read_i | ch_write_i;

    // Winner: first requester at or above base, else the lowest requester (wrap-around).
    always_comb begin
        base     = (arb_mode == 1) ? '0 : rr_ptr_q;
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int unsigned k = 0; k < num_channels; k++) begin
            if (req[k] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = ptr_t'(k);
            end
            if (req[k] && !hi_found && (k >= 32'(base))) begin
                hi_found = 1'b1;
                hi_idx   = ptr_t'(k);
            end
        end
        found_d = lo_found;
        idx_d   = hi_found ? hi_idx : lo_idx;
    end

    // Winner payload; a simultaneous write overrides the read.
    always_comb begin
        grant_d = '0;
        addr_d  = '0;
        wdata_d = '0;
        read_d  = 1'b0;
        write_d = 1'b0;
        for (int unsigned k = 0; k < num_channels; k++) begin
            if (ptr_t'(k) == idx_d) begin
                grant_d[k] = found_d;
                addr_d     = ch_addr_i[k*addr_width +: addr_width];
                wdata_d    = ch_wdata_i[k*data_width +: data_width];
                write_d    = ch_write_i[k];
                read_d     = ch_read_i[k] & ~ch_write_i[k];
            end
        end
    end

    assign rr_ptr_d = (32'(gnt_idx_q) == (num_channels - 1)) ? '0 : gnt_idx_q + ptr_t'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gnt_idx_q   <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        state_q     <= BUSY;
                        gnt_idx_q   <= idx_d;
                        grant_q     <= grant_d;
                        busy_q      <= 1'b1;
                        mem_read_q  <= read_d;
                        mem_write_q <= write_d;
                        mem_addr_q  <= addr_d;
                        mem_wdata_q <= wdata_d;
                    end
                end
                BUSY: begin
                    if (mem_resp_i) begin
                        state_q     <= IDLE;
                        grant_q     <= '0;
                        busy_q      <= 1'b0;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (arb_mode == 0) begin
                            rr_ptr_q <= rr_ptr_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Completion is routed to the owner in the same cycle as mem_resp_i.
    always_comb begin
        ch_resp_o  = '0;
        ch_rdata_o = '0;
        for (int unsigned k = 0; k < num_channels; k++) begin
            if ((state_q == BUSY) && mem_resp_i && grant_q[k]) begin
                ch_resp_o[k]                           = 1'b1;
                ch_rdata_o[k*data_width +: data_width] = mem_rdata_i;
            end
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign mem_read_o  = mem_read_q;
    assign mem_write_o = mem_write_q;
    assign mem_wdata_o = mem_wdata_q;
    assign grant_o     = grant_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_rvga_membus_arbiter.sv
// Bench for rvga_membus_arbiter: 2-channel round-robin and fixed-priority instances
// sharing stimulus, plus a 4-channel round-robin instance for wrap-around.
module tb_rvga_membus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  rd, wr;
    logic [63:0] addr, wdata;
    logic [31:0] mrdata;
    logic        mresp;

    logic [63:0] a_rdata, b_rdata;
    logic [1:0]  a_resp, b_resp, a_grant, b_grant;
    logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
    logic        a_rd, b_rd, a_wr, b_wr, a_busy, b_busy;

    logic [3:0]   rd4, wr4;
    logic [127:0] addr4, wdata4, c_rdata;
    logic [31:0]  mrdata4, c_addr, c_wdata;
    logic         mresp4, c_rd, c_wr, c_busy;
    logic [3:0]   c_resp, c_grant;

    rvga_membus_arbiter #(.num_channels(2), .addr_width(32), .data_width(32), .arb_mode(0)) u_rr (
        .clk_i(clk), .rst_i(rst), .ch_addr_i(addr), .ch_read_i(rd), .ch_write_i(wr),
        .ch_wdata_i(wdata), .ch_rdata_o(a_rdata), .ch_resp_o(a_resp), .mem_addr_o(a_addr),
        .mem_read_o(a_rd), .mem_write_o(a_wr), .mem_wdata_o(a_wdata), .mem_rdata_i(mrdata),
        .mem_resp_i(mresp), .grant_o(a_grant), .busy_o(a_busy));

    rvga_membus_arbiter #(.num_channels(2), .addr_width(32), .data_width(32), .arb_mode(1)) u_fp (
        .clk_i(clk), .rst_i(rst), .ch_addr_i(addr), .ch_read_i(rd), .ch_write_i(wr),
        .ch_wdata_i(wdata), .ch_rdata_o(b_rdata), .ch_resp_o(b_resp), .mem_addr_o(b_addr),
        .mem_read_o(b_rd), .mem_write_o(b_wr), .mem_wdata_o(b_wdata), .mem_rdata_i(mrdata),
        .mem_resp_i(mresp), .grant_o(b_grant), .busy_o(b_busy));

    rvga_membus_arbiter #(.num_channels(4), .addr_width(32), .data_width(32), .arb_mode(0)) u_rr4 (
        .clk_i(clk), .rst_i(rst), .ch_addr_i(addr4), .ch_read_i(rd4), .ch_write_i(wr4),
        .ch_wdata_i(wdata4), .ch_rdata_o(c_rdata), .ch_resp_o(c_resp), .mem_addr_o(c_addr),
        .mem_read_o(c_rd), .mem_write_o(c_wr), .mem_wdata_o(c_wdata), .mem_rdata_i(mrdata4),
        .mem_resp_i(mresp4), .grant_o(c_grant), .busy_o(c_busy));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input string name);
        int c = 0;
        while (!a_busy && c < 20) begin
            tick();
            c++;
        end
        chk(name, 64'(a_busy), 64'd1);
    endtask

    task automatic wait_busy4(input string name);
        int c = 0;
        while (!c_busy && c < 20) begin
            tick();
            c++;
        end
        chk(name, 64'(c_busy), 64'd1);
    endtask

    // Reference arbitration: search upward from the pointer with wrap-around.
    function automatic int rr_pick(input int ptr, input logic [1:0] req);
        for (int off = 0; off < 2; off++) begin
            if (req[(ptr + off) % 2]) return (ptr + off) % 2;
        end
        return -1;
    endfunction

    typedef struct {
        logic [1:0]  rd, wr;
        logic [31:0] a0, a1, wd0;
        logic        resp;
        logic [31:0] rdat;
        logic        e_rd, e_wr;
        logic [31:0] e_addr, e_wdata;
        logic [1:0]  e_grant;
        logic        e_busy;
        logic [1:0]  e_resp;
        logic [63:0] e_rdata;
    } vec_t;

    vec_t vecs[10];

    logic [1:0]  r, w, rq;
    logic [31:0] ad[2], wd[2], rdat;
    int          wa, wb, ptr_m, d;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{2'b00, 2'b00, 32'h0,   32'h0,   32'h0,    1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,    2'b00, 1'b0, 2'b00, 64'h0};
        vecs[1] = '{2'b10, 2'b00, 32'h0,   32'h100, 32'h0,    1'b0, 32'h0,        1'b0, 1'b0, 32'h0,   32'h0,    2'b00, 1'b0, 2'b00, 64'h0};
        vecs[2] = '{2'b10, 2'b00, 32'h0,   32'h100, 32'h0,    1'b0, 32'h0,        1'b1, 1'b0, 32'h100, 32'h0,    2'b10, 1'b1, 2'b00, 64'h0};
        vecs[3] = '{2'b10, 2'b00, 32'h0,   32'h100, 32'h0,    1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h100, 32'h0,    2'b10, 1'b1, 2'b10, 64'hDEADBEEF_00000000};
        vecs[4] = '{2'b00, 2'b00, 32'h0,   32'h0,   32'h0,    1'b0, 32'h0,        1'b0, 1'b0, 32'h100, 32'h0,    2'b00, 1'b0, 2'b00, 64'h0};
        vecs[5] = '{2'b01, 2'b01, 32'h20,  32'h0,   32'h55AA, 1'b0, 32'h0,        1'b0, 1'b0, 32'h100, 32'h0,    2'b00, 1'b0, 2'b00, 64'h0};
        vecs[6] = '{2'b00, 2'b00, 32'h999, 32'h0,   32'h1111, 1'b0, 32'h0,        1'b0, 1'b1, 32'h20,  32'h55AA, 2'b01, 1'b1, 2'b00, 64'h0};
        vecs[7] = '{2'b00, 2'b00, 32'h999, 32'h0,   32'h1111, 1'b0, 32'h0,        1'b0, 1'b1, 32'h20,  32'h55AA, 2'b01, 1'b1, 2'b00, 64'h0};
        vecs[8] = '{2'b00, 2'b00, 32'h999, 32'h0,   32'h1111, 1'b1, 32'h1234,     1'b0, 1'b1, 32'h20,  32'h55AA, 2'b01, 1'b1, 2'b01, 64'h1234};
        vecs[9] = '{2'b00, 2'b00, 32'h0,   32'h0,   32'h0,    1'b0, 32'h0,        1'b0, 1'b0, 32'h20,  32'h55AA, 2'b00, 1'b0, 2'b00, 64'h0};

        rst = 1'b1; rd = '0; wr = '0; addr = '0; wdata = '0; mrdata = '0; mresp = 1'b0;
        rd4 = '0; wr4 = '0; addr4 = '0; wdata4 = '0; mrdata4 = '0; mresp4 = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Single read, then write-with-read priority and request drop during BUSY.
        for (int i = 0; i < 10; i++) begin
            rd = vecs[i].rd; wr = vecs[i].wr;
            addr = {vecs[i].a1, vecs[i].a0};
            wdata = {32'h0, vecs[i].wd0};
            mresp = vecs[i].resp; mrdata = vecs[i].rdat;
            #1;
            chk($sformatf("v%0d_rd", i),    64'(a_rd),    64'(vecs[i].e_rd));
            chk($sformatf("v%0d_wr", i),    64'(a_wr),    64'(vecs[i].e_wr));
            chk($sformatf("v%0d_addr", i),  64'(a_addr),  64'(vecs[i].e_addr));
            chk($sformatf("v%0d_wdata", i), 64'(a_wdata), 64'(vecs[i].e_wdata));
            chk($sformatf("v%0d_grant", i), 64'(a_grant), 64'(vecs[i].e_grant));
            chk($sformatf("v%0d_busy", i),  64'(a_busy),  64'(vecs[i].e_busy));
            chk($sformatf("v%0d_resp", i),  64'(a_resp),  64'(vecs[i].e_resp));
            chk($sformatf("v%0d_rdata", i), a_rdata,      vecs[i].e_rdata);
            tick();
        end

        // Both channels requesting continuously: RR alternates, fixed priority sticks to 0.
        rst = 1'b1; rd = '0; wr = '0; mresp = 1'b0;
        tick();
        rst = 1'b0;
        rd = 2'b11; addr = {32'h200, 32'h100}; wdata = '0;
        for (int t = 0; t < 4; t++) begin
            wait_busy($sformatf("rr_busy%0d", t));
            chk($sformatf("rr_grant%0d", t), 64'(a_grant), (t % 2 == 0) ? 64'd1 : 64'd2);
            chk($sformatf("fp_grant%0d", t), 64'(b_grant), 64'd1);
            tick();
            tick();
            mresp = 1'b1; mrdata = 32'hA0 + 32'(t);
            #1;
            chk($sformatf("rr_resp%0d", t), 64'(a_resp), (t % 2 == 0) ? 64'd1 : 64'd2);
            chk($sformatf("fp_resp%0d", t), 64'(b_resp), 64'd1);
            tick();
            mresp = 1'b0;
        end

        // Reset while BUSY abandons the transaction; a late resp is ignored.
        rd = 2'b01;
        tick();
        chk("rst_pre_busy", 64'(a_busy), 64'd1);
        rd = 2'b00;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy",  64'(a_busy),  64'd0);
        chk("rst_grant", 64'(a_grant), 64'd0);
        chk("rst_rd",    64'(a_rd),    64'd0);
        chk("rst_addr",  64'(a_addr),  64'd0);
        tick();
        mresp = 1'b1; mrdata = 32'hBAD0BAD0;
        #1;
        chk("late_resp_rr",  64'(a_resp), 64'd0);
        chk("late_resp_fp",  64'(b_resp), 64'd0);
        chk("late_rdata_rr", a_rdata,     64'd0);
        tick();
        mresp = 1'b0;
        chk("late_busy", 64'(a_busy), 64'd0);
        rd = 2'b10;
        tick();
        chk("post_rst_grant", 64'(a_grant), 64'd2);
        chk("post_rst_rd",    64'(a_rd),    64'd1);
        mresp = 1'b1; mrdata = 32'h77;
        #1;
        chk("post_rst_resp", 64'(a_resp), 64'd2);
        tick();
        mresp = 1'b0; rd = 2'b00;
        chk("post_rst_idle", 64'(a_busy), 64'd0);

        // Four channels: drive rr_ptr to 3, then 0 and 2 request -> wrap to 0, then 2.
        addr4 = {32'h3000, 32'h2000, 32'h1000, 32'h40};
        rd4 = 4'b0100;
        wait_busy4("c_busy_a");
        chk("c_grant_a", 64'(c_grant), 64'h4);
        rd4 = 4'b0000; mresp4 = 1'b1;
        #1;
        chk("c_resp_a", 64'(c_resp), 64'h4);
        tick();
        mresp4 = 1'b0; rd4 = 4'b0101;
        wait_busy4("c_busy_b");
        chk("c_grant_wrap", 64'(c_grant), 64'h1);
        chk("c_addr_wrap",  64'(c_addr),  64'h40);
        mresp4 = 1'b1; mrdata4 = 32'hCAFE;
        #1;
        chk("c_rdata_wrap", 64'(c_rdata[31:0]), 64'hCAFE);
        tick();
        mresp4 = 1'b0;
        wait_busy4("c_busy_c");
        chk("c_grant_after", 64'(c_grant), 64'h4);
        mresp4 = 1'b1;
        #1;
        tick();
        mresp4 = 1'b0; rd4 = 4'b0000;

        // Randomized traffic against the reference model.
        rst = 1'b1; rd = '0; wr = '0; mresp = 1'b0;
        tick();
        rst = 1'b0;
        ptr_m = 0;
        for (int it = 0; it < 60; it++) begin
            r = 2'($urandom); w = 2'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                r = 2'b00; w = 2'b00;
            end
            ad[0] = $urandom; ad[1] = $urandom; wd[0] = $urandom; wd[1] = $urandom;
            rd = r; wr = w; addr = {ad[1], ad[0]}; wdata = {wd[1], wd[0]};
            rq = r | w;
            tick();
            if (rq == 2'b00) begin
                chk("rnd_idle_rr", 64'(a_busy), 64'd0);
                chk("rnd_idle_fp", 64'(b_busy), 64'd0);
                continue;
            end
            wa = rr_pick(ptr_m, rq);
            wb = rq[0] ? 0 : 1;
            chk("rnd_grant_rr", 64'(a_grant), 64'd1 << wa);
            chk("rnd_grant_fp", 64'(b_grant), 64'd1 << wb);
            chk("rnd_addr_rr",  64'(a_addr),  64'(ad[wa]));
            chk("rnd_addr_fp",  64'(b_addr),  64'(ad[wb]));
            chk("rnd_wdata_rr", 64'(a_wdata), 64'(wd[wa]));
            chk("rnd_wr_rr",    64'(a_wr),    64'(w[wa]));
            chk("rnd_rd_rr",    64'(a_rd),    64'(r[wa] & ~w[wa]));
            chk("rnd_wr_fp",    64'(b_wr),    64'(w[wb]));
            chk("rnd_rd_fp",    64'(b_rd),    64'(r[wb] & ~w[wb]));
            rd = 2'($urandom); wr = 2'($urandom);
            addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
            d = $urandom_range(0, 3);
            for (int j = 0; j < d; j++) begin
                tick();
                chk("rnd_hold_addr", 64'(a_addr), 64'(ad[wa]));
                chk("rnd_hold_busy", 64'(a_busy), 64'd1);
            end
            rdat = $urandom;
            mresp = 1'b1; mrdata = rdat;
            #1;
            chk("rnd_resp_rr",  64'(a_resp), 64'd1 << wa);
            chk("rnd_resp_fp",  64'(b_resp), 64'd1 << wb);
            chk("rnd_rdata_rr", a_rdata,     {32'h0, rdat} << (32 * wa));
            chk("rnd_rdata_fp", b_rdata,     {32'h0, rdat} << (32 * wb));
            tick();
            mresp = 1'b0;
            chk("rnd_done_busy",  64'(a_busy),  64'd0);
            chk("rnd_done_grant", 64'(a_grant), 64'd0);
            chk("rnd_done_strb",  64'({a_rd, a_wr, b_rd, b_wr}), 64'd0);
            ptr_m = (wa + 1) % 2;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
